ifetch: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Accepts one fetch address per cycle from the PC stage over a valid/ready handshake and issues it to instruction memory over a request/grant bus. It tracks in-order responses with variable latency and buffers fetched instructions with their PC for the decode stage. On a pipeline flush it discards in-flight responses and buffered instructions so decode never sees wrong-path instructions.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 78 +++++++
 rtl/ifetch.sv | 147 ++++++++++++++
 tb/tb_ifetch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: definitions shared by the instruction fetch stage.
//   - default address/instruction width and buffer depth
//   - fetch FSM state encoding
//   - width of one buffered fetch entry {pc, instr, err}
package ifetch_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned IBUF_DEPTH_DEFAULT = 2;

  // RUN: issuing and collecting responses.
  // DRAIN: swallowing responses of requests that were in flight at a flush.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  // One instruction-buffer entry is {pc, instr, err}.
  function automatic int unsigned fetch_entry_width(input int unsigned xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO with occupancy count.
//   clk, rst_n       : clock, async active-low reset
//   clear            : synchronous discard of all entries (priority over push/pop)
//   push, push_data  : write an entry; accepted when not full or when popping
//   pop, pop_data    : remove the head entry; pop_data always shows the head
//   count/full/empty : occupancy status, all registered
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage is reset too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage between the PC stage and decode.
//   pc_valid/pc_in/pc_ready    : fetch address in; pc_ready = request granted
//   flush                      : kill all fetch state (wrong-path redirect)
//   imem_req/addr/gnt          : request bus to instruction memory
//   imem_rvalid/rdata/err      : in-order responses with variable latency
//   id_valid/ready/pc/instr/fault : buffered instruction towards decode
//   dbg_state/dbg_drop_cnt     : FSM state and number of responses still to drop
//
// Handshakes: a transfer happens on a cycle where valid (pc_valid, imem_req,
// id_valid) and its ready/grant (pc_ready, imem_gnt, id_ready) are both high.
// imem_req drops without a grant only on flush, reset or loss of pc_valid;
// id_* hold stable while id_valid=1 and id_ready=0.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned IBUF_DEPTH = IBUF_DEPTH_DEFAULT,
  localparam int unsigned CW        = $clog2(IBUF_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            id_fault,
  output fetch_state_e    dbg_state,
  output logic [CW-1:0]   dbg_drop_cnt
);

  localparam int unsigned EW = fetch_entry_width(XLEN);

  fetch_state_e  state_q, state_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic            pq_push, pq_pop, pq_full, pq_empty;
  logic [XLEN-1:0] pq_head;
  logic [CW-1:0]   pq_count;
  logic            ib_push, ib_pop, ib_full, ib_empty;
  logic [EW-1:0]   ib_head, ib_data;
  logic [CW-1:0]   ib_count;

  logic          run, credit;
  logic [CW:0]   in_use;
  logic [CW-1:0] live;

  ifetch_fifo #(.WIDTH(XLEN), .DEPTH(IBUF_DEPTH)) u_pc_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .push     (pq_push),
    .push_data(pc_in),
    .pop      (pq_pop),
    .pop_data (pq_head),
    .count    (pq_count),
    .full     (pq_full),
    .empty    (pq_empty)
  );

  ifetch_fifo #(.WIDTH(EW), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .push     (ib_push),
    .push_data(ib_data),
    .pop      (ib_pop),
    .pop_data (ib_head),
    .count    (ib_count),
    .full     (ib_full),
    .empty    (ib_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Requests still owed a response: pending-PC entries in RUN, the drop
  // counter in DRAIN (the PC queue was emptied at the flush).
  assign live = (state_q == ST_RUN) ? pq_count : drop_cnt_q;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      // No grant is possible in a flush cycle; a response this cycle is
      // discarded and retires one of the live requests.
      if (imem_rvalid && (live != '0)) drop_cnt_d = live - CW'(1);
      else                             drop_cnt_d = live;
      state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
    end else if ((state_q == ST_DRAIN) && imem_rvalid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
      if (drop_cnt_d == '0) state_d = ST_RUN;
    end
  end

  // Credit counts the slot freed by a decode pop this cycle, which is what
  // sustains one instruction per cycle at depth 2.
  assign in_use = {1'b0, pq_count} + {1'b0, ib_count} - (CW + 1)'(ib_pop);
  assign credit = (in_use < (CW + 1)'(IBUF_DEPTH));

  // Output logic.
  always_comb begin
    run       = (state_q == ST_RUN);
    imem_req  = rst_n & run & pc_valid & credit & ~flush;
    imem_addr = imem_req ? pc_in : '0;
    pc_ready  = imem_req & imem_gnt;
    pq_push   = pc_ready;
    // A stray response with nothing pending is ignored.
    pq_pop    = run & ~flush & imem_rvalid & ~pq_empty;
    ib_push   = pq_pop;
    ib_data   = {pq_head, imem_rdata, imem_err};
    id_valid  = ~ib_empty;
    ib_pop    = id_valid & id_ready;
  end

  assign id_pc        = ib_head[EW-1 -: XLEN];
  assign id_instr     = ib_head[XLEN:1];
  assign id_fault     = ib_head[0];
  assign dbg_state    = state_q;
  assign dbg_drop_cnt = drop_cnt_q;

  a_rvalid_with_pending : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (state_q == ST_RUN) && pq_empty));
  a_pq_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pq_push && pq_full && !pq_pop));
  a_ib_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(ib_push && ib_full && !ib_pop));

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid, pc_ready, flush;
  logic [31:0] pc_in;
  logic        imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready, id_fault;
  logic [31:0] id_pc, id_instr;
  fetch_state_e dbg_state;
  logic [1:0]  dbg_drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pv;     logic [31:0] pc;   logic gnt;
    logic        rv;     logic [31:0] rv_pc; logic er;
    logic        idr;    logic fl;
    logic        e_req;  logic e_rdy;
    logic        e_idv;  logic [31:0] e_pc; logic e_flt;
  } vec_t;

  vec_t tbl[$];

  // clock / reset
  always #5 clk = ~clk;

  ifetch #(.XLEN(32), .IBUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_instr(id_instr), .id_fault(id_fault),
    .dbg_state(dbg_state), .dbg_drop_cnt(dbg_drop_cnt)
  );

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  function automatic vec_t mk(
    input logic pv, input logic [31:0] pc, input logic gnt,
    input logic rv, input logic [31:0] rv_pc, input logic er,
    input logic idr, input logic fl,
    input logic e_req, input logic e_rdy,
    input logic e_idv, input logic [31:0] e_pc, input logic e_flt);
    vec_t v;
    v.pv = pv; v.pc = pc; v.gnt = gnt; v.rv = rv; v.rv_pc = rv_pc; v.er = er;
    v.idr = idr; v.fl = fl; v.e_req = e_req; v.e_rdy = e_rdy;
    v.e_idv = e_idv; v.e_pc = e_pc; v.e_flt = e_flt;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs at the falling edge, compare 1ns later
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    pc_valid    = v.pv;
    pc_in       = v.pc;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rv ? instr_of(v.rv_pc) : 32'h0;
    imem_err    = v.er;
    id_ready    = v.idr;
    flush       = v.fl;
    #1;
    chk($sformatf("%s.imem_req", tag), 32'(imem_req), 32'(v.e_req));
    chk($sformatf("%s.pc_ready", tag), 32'(pc_ready), 32'(v.e_rdy));
    if (v.e_req) chk($sformatf("%s.imem_addr", tag), imem_addr, v.pc);
    chk($sformatf("%s.id_valid", tag), 32'(id_valid), 32'(v.e_idv));
    if (v.e_idv) begin
      chk($sformatf("%s.id_pc", tag), id_pc, v.e_pc);
      chk($sformatf("%s.id_instr", tag), id_instr, instr_of(v.e_pc));
      chk($sformatf("%s.id_fault", tag), 32'(id_fault), 32'(v.e_flt));
    end
  endtask

  task automatic check_dbg(input fetch_state_e st, input logic [1:0] cnt, input string tag);
    chk($sformatf("%s.state", tag), 32'(dbg_state), 32'(st));
    chk($sformatf("%s.drop_cnt", tag), 32'(dbg_drop_cnt), 32'(cnt));
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) step(tbl[i], $sformatf("%s%0d", tag, i));
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // reset: outputs must be at their reset values even with pc_valid high
    rst_n = 1'b0; pc_valid = 1'b1; pc_in = 32'h123; flush = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
    id_ready = 1'b0;
    #1;
    chk("rst.imem_req", 32'(imem_req), 32'd0);
    chk("rst.pc_ready", 32'(pc_ready), 32'd0);
    chk("rst.imem_addr", imem_addr, 32'd0);
    chk("rst.id_valid", 32'(id_valid), 32'd0);
    chk("rst.id_pc", id_pc, 32'd0);
    chk("rst.id_instr", id_instr, 32'd0);
    chk("rst.id_fault", 32'(id_fault), 32'd0);
    check_dbg(ST_RUN, 2'd0, "rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    pc_valid = 1'b0;
    rst_n = 1'b1;

    // streaming, 1-cycle memory, decode always ready
    tbl.push_back(mk(1, 'h0, 1, 0, 0,   0, 1, 0, 1, 1, 0, 0,   0));
    tbl.push_back(mk(1, 'h4, 1, 1, 'h0, 0, 1, 0, 1, 1, 0, 0,   0));
    tbl.push_back(mk(1, 'h8, 1, 1, 'h4, 0, 1, 0, 1, 1, 1, 'h0, 0));
    tbl.push_back(mk(1, 'hC, 1, 1, 'h8, 0, 1, 0, 1, 1, 1, 'h4, 0));
    tbl.push_back(mk(0, 'h0, 0, 1, 'hC, 0, 1, 0, 0, 0, 1, 'h8, 0));
    tbl.push_back(mk(0, 'h0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 'hC, 0));
    tbl.push_back(mk(0, 'h0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0,   0));
    run_tbl("stream");

    // decode stalls 5 cycles: credit runs out, head holds, then resumes
    tbl.push_back(mk(1, 'h20, 1, 0, 0,    0, 0, 0, 1, 1, 0, 0,    0));
    tbl.push_back(mk(1, 'h24, 1, 1, 'h20, 0, 0, 0, 1, 1, 0, 0,    0));
    tbl.push_back(mk(1, 'h28, 1, 1, 'h24, 0, 0, 0, 0, 0, 1, 'h20, 0));
    tbl.push_back(mk(1, 'h28, 1, 0, 0,    0, 0, 0, 0, 0, 1, 'h20, 0));
    tbl.push_back(mk(1, 'h28, 1, 0, 0,    0, 0, 0, 0, 0, 1, 'h20, 0));
    tbl.push_back(mk(1, 'h28, 1, 0, 0,    0, 1, 0, 1, 1, 1, 'h20, 0));
    tbl.push_back(mk(1, 'h2C, 1, 1, 'h28, 0, 1, 0, 1, 1, 1, 'h24, 0));
    tbl.push_back(mk(0, 'h0,  0, 1, 'h2C, 0, 1, 0, 0, 0, 1, 'h28, 0));
    tbl.push_back(mk(0, 'h0,  0, 0, 0,    0, 1, 0, 0, 0, 1, 'h2C, 0));
    tbl.push_back(mk(0, 'h0,  0, 0, 0,    0, 1, 0, 0, 0, 0, 0,    0));
    run_tbl("stall");

    // 3-cycle memory, flush with two requests outstanding
    step(mk(1, 'h40, 1, 0, 0,    0, 1, 0, 1, 1, 0, 0, 0), "fl0");
    step(mk(1, 'h44, 1, 0, 0,    0, 1, 0, 1, 1, 0, 0, 0), "fl1");
    step(mk(1, 'h48, 1, 0, 0,    0, 1, 1, 0, 0, 0, 0, 0), "fl2");
    step(mk(1, 'h80, 1, 1, 'h40, 0, 1, 0, 0, 0, 0, 0, 0), "fl3");
    check_dbg(ST_DRAIN, 2'd2, "fl3");
    step(mk(1, 'h80, 1, 1, 'h44, 0, 1, 0, 0, 0, 0, 0, 0), "fl4");
    check_dbg(ST_DRAIN, 2'd1, "fl4");
    step(mk(1, 'h80, 1, 0, 0,    0, 1, 0, 1, 1, 0, 0, 0), "fl5");
    check_dbg(ST_RUN, 2'd0, "fl5");
    step(mk(0, 'h0,  0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0), "fl6");
    step(mk(0, 'h0,  0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0), "fl7");
    step(mk(0, 'h0,  0, 1, 'h80, 0, 1, 0, 0, 0, 0, 0, 0), "fl8");
    step(mk(0, 'h0,  0, 0, 0,    0, 1, 0, 0, 0, 1, 'h80, 0), "fl9");
    step(mk(0, 'h0,  0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0), "fl10");

    // flush in the same cycle as the only outstanding response
    step(mk(1, 'h90, 1, 0, 0,    0, 1, 0, 1, 1, 0, 0, 0), "fr0");
    step(mk(1, 'h94, 1, 1, 'h90, 0, 1, 1, 0, 0, 0, 0, 0), "fr1");
    step(mk(1, 'h94, 1, 0, 0,    0, 1, 0, 1, 1, 0, 0, 0), "fr2");
    check_dbg(ST_RUN, 2'd0, "fr2");
    step(mk(0, 'h0,  0, 1, 'h94, 0, 1, 0, 0, 0, 0, 0, 0), "fr3");
    step(mk(0, 'h0,  0, 0, 0,    0, 1, 0, 0, 0, 1, 'h94, 0), "fr4");
    step(mk(0, 'h0,  0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0), "fr5");

    // bus error carried with its instruction only
    tbl.push_back(mk(1, 'h100, 1, 0, 0,     0, 1, 0, 1, 1, 0, 0,     0));
    tbl.push_back(mk(1, 'h104, 1, 1, 'h100, 1, 1, 0, 1, 1, 0, 0,     0));
    tbl.push_back(mk(0, 'h0,   0, 1, 'h104, 0, 1, 0, 0, 0, 1, 'h100, 1));
    tbl.push_back(mk(0, 'h0,   0, 0, 0,     0, 1, 0, 0, 0, 1, 'h104, 0));
    tbl.push_back(mk(0, 'h0,   0, 0, 0,     0, 1, 0, 0, 0, 0, 0,     0));
    run_tbl("err");

    // reset mid-transaction: one buffered, one pending, request active
    step(mk(1, 'h200, 1, 0, 0,     0, 1, 0, 1, 1, 0, 0, 0), "rs0");
    step(mk(1, 'h204, 1, 1, 'h200, 0, 0, 0, 1, 1, 0, 0, 0), "rs1");
    step(mk(1, 'h208, 0, 0, 0,     0, 1, 0, 1, 0, 1, 'h200, 0), "rs2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs.async.id_valid", 32'(id_valid), 32'd0);
    chk("rs.async.imem_req", 32'(imem_req), 32'd0);
    pc_valid = 1'b0; imem_gnt = 1'b0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_dbg(ST_RUN, 2'd0, "rs.rel");
    step(mk(1, 'h300, 1, 0, 0,     0, 1, 0, 1, 1, 0, 0,     0), "rs3");
    step(mk(0, 'h0,   0, 1, 'h300, 0, 1, 0, 0, 0, 0, 0,     0), "rs4");
    step(mk(0, 'h0,   0, 0, 0,     0, 1, 0, 0, 0, 1, 'h300, 0), "rs5");
    step(mk(0, 'h0,   0, 0, 0,     0, 1, 0, 0, 0, 0, 0,     0), "rs6");

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
